// File: rtl/tactile_visualizer.sv
// tactile_visualizer
// Stores one 12-bit taxel reading per clock into a SW_WIRE_CNT x RD_WIRE_CNT frame
// buffer (raster order) and renders the buffer as a red/blue heatmap on a raster display.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   hcount     - pixel x coordinate (11 bits)
//   vcount     - pixel y coordinate (10 bits)
//   data_in    - taxel reading, written every clock
//   red/green/blue - registered pixel colour, valid two clocks after hcount/vcount
//   frame_done - one-cycle pulse after the last taxel of a frame is written
module tactile_visualizer #(
  parameter int unsigned SW_WIRE_CNT = 16,
  parameter int unsigned RD_WIRE_CNT = 16,
  parameter int unsigned CELL_LOG2   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [11:0] data_in,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_done
);

  localparam int unsigned N  = SW_WIRE_CNT * RD_WIRE_CNT;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LastIdx = PW'(N - 1);

  logic [11:0]   r_mem [N];
  logic [PW-1:0] r_wp;
  logic          r_frame_done;
  logic [PW-1:0] r_addr;
  logic          r_in_grid;
  logic          r_grid_d;
  logic [11:0]   r_q;
  logic [7:0]    r_red;
  logic [7:0]    r_green;
  logic [7:0]    r_blue;

  logic [31:0]   w_col;
  logic [31:0]   w_row;
  logic          w_in_grid;
  logic [PW-1:0] w_addr;
  logic [7:0]    w_v;
  logic          w_unused_q_lsb;

  // Write pointer and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_wp == LastIdx);
      r_wp         <= (r_wp == LastIdx) ? '0 : r_wp + 1'b1;
    end
  end

  // Frame buffer: no reset so it maps onto block RAM. Writes are held off while
  // reset is asserted so buffer contents survive a mid-frame reset. The read uses
  // the pre-write contents, giving read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[r_wp] <= data_in;
    end
    r_q <= r_mem[r_addr];
  end

  // Pixel to taxel cell. Full-width compare first; truncation only when in the grid.
  assign w_col     = 32'(hcount >> CELL_LOG2);
  assign w_row     = 32'(vcount >> CELL_LOG2);
  assign w_in_grid = (w_col < SW_WIRE_CNT) && (w_row < RD_WIRE_CNT);
  assign w_addr    = w_in_grid ? PW'(w_row * SW_WIRE_CNT + w_col) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_in_grid <= 1'b0;
      r_grid_d  <= 1'b0;
    end else begin
      r_addr    <= w_addr;
      r_in_grid <= w_in_grid;
      r_grid_d  <= r_in_grid;
    end
  end

  // Colour map: top 8 bits of the reading blend blue (low) to red (high).
  assign w_v            = r_q[11:4];
  assign w_unused_q_lsb = ^r_q[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_red   <= 8'h00;
      r_green <= 8'h00;
      r_blue  <= 8'h00;
    end else if (r_grid_d) begin
      r_red   <= w_v;
      r_green <= 8'h00;
      r_blue  <= 8'hFF - w_v;
    end else begin
      r_red   <= 8'h00;
      r_green <= 8'h00;
      r_blue  <= 8'h00;
    end
  end

  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tactile_visualizer.sv
module tb_tactile_visualizer;

  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int CELL = 32;
  localparam int N    = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] data_in;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_done;

  tactile_visualizer #(
    .SW_WIRE_CNT(16),
    .RD_WIRE_CNT(16),
    .CELL_LOG2  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .data_in   (data_in),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;

  // Reference model: taxel array, known-written flags, write pointer and a
  // two-deep latency line of expected colours ({known, r, g, b}).
  int          mem_m   [N];
  bit          written [N];
  int          wp_m;
  logic [24:0] s1;
  logic [24:0] s2;
  logic [24:0] out_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] colour(input int x, input int y);
    int c;
    int r;
    int v;
    c = x / CELL;
    r = y / CELL;
    if (c >= COLS || r >= ROWS) return {1'b1, 24'h0};
    if (!written[r * COLS + c]) return '0;
    v = mem_m[r * COLS + c] / 16;
    return {1'b1, 8'(v), 8'h00, 8'(255 - v)};
  endfunction

  // One clock: update the model for this edge, then check the DUT after it.
  task automatic step();
    logic exp_fd;
    exp_fd = rst && (wp_m == N - 1);
    if (rst) begin
      mem_m[wp_m]   = int'(data_in);
      written[wp_m] = 1'b1;
      wp_m          = (wp_m + 1) % N;
      out_exp       = s2;
      s2            = s1;
      s1            = colour(int'(hcount), int'(vcount));
    end else begin
      out_exp = {1'b1, 24'h0};
      s1      = {1'b1, 24'h0};
      s2      = {1'b1, 24'h0};
    end
    @(posedge clk);
    #1;
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (frame_done === 1'b1) fd_count++;
    if (out_exp[24]) chk("rgb", {8'h00, red, green, blue}, {8'h00, out_exp[23:0]});
  endtask

  task automatic rand_pixel();
    hcount = 11'($urandom_range(0, 700));
    vcount = 10'($urandom_range(0, 600));
  endtask

  initial begin
    rst     = 1'b1;
    hcount  = '0;
    vcount  = '0;
    data_in = '0;
    wp_m    = 0;
    s1      = {1'b1, 24'h0};
    s2      = {1'b1, 24'h0};

    // Reset state
    #2;
    rst = 1'b0;
    #1;
    chk("reset_rgb", {8'h00, red, green, blue}, 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    step();
    step();
    rst = 1'b1;

    // Ramp: data 1,2,3,... for 4096 cycles, 16 frame_done pulses
    fd_count = 0;
    for (int i = 0; i < 4096; i++) begin
      data_in = 12'((i + 1) % 4096);
      if (i == 4094) begin
        hcount = 11'd10;
        vcount = 10'd10;
      end else if (i == 4095) begin
        hcount = 11'd64;
        vcount = 10'd32;
      end else begin
        rand_pixel();
      end
      step();
    end
    chk("fd_pulses", 32'(fd_count), 32'd16);
    data_in = 12'($urandom);
    step();
    chk("ramp_cell0", {8'h00, red, green, blue}, 32'h00F0000F);
    step();
    chk("ramp_cell18", {8'h00, red, green, blue}, 32'h00F1000E);

    // Uniform frame
    data_in = 12'hFF0;
    for (int i = 0; i < N; i++) begin
      rand_pixel();
      step();
    end
    hcount = 11'd10;
    vcount = 10'd10;
    step();
    step();
    step();
    chk("uniform_rgb", {8'h00, red, green, blue}, 32'h00FF0000);

    // Out-of-grid
    hcount = 11'd600;
    vcount = 10'd10;
    step();
    step();
    step();
    chk("oog_col", {8'h00, red, green, blue}, 32'h0);
    hcount = 11'd10;
    vcount = 10'd700;
    step();
    step();
    step();
    chk("oog_row", {8'h00, red, green, blue}, 32'h0);

    // Collision on index 5: old 12'h100, new 12'h800
    while (wp_m != 5) begin
      data_in = 12'($urandom);
      step();
    end
    data_in = 12'h100;
    step();
    hcount = 11'd160;
    vcount = 10'd0;
    while (wp_m != 4) begin
      data_in = 12'($urandom);
      step();
    end
    step();
    data_in = 12'h800;
    step();
    data_in = 12'($urandom);
    step();
    chk("collision_old", {8'h00, red, green, blue}, 32'h001000EF);
    step();
    chk("collision_new", {8'h00, red, green, blue}, 32'h0080007F);

    // Random traffic then a mid-frame reset
    for (int i = 0; i < 40; i++) begin
      data_in = 12'($urandom);
      rand_pixel();
      step();
    end
    #3;
    rst  = 1'b0;
    wp_m = 0;
    #1;
    chk("midreset_rgb", {8'h00, red, green, blue}, 32'h0);
    chk("midreset_fd", 32'(frame_done), 32'h0);
    step();
    step();
    rst     = 1'b1;
    data_in = 12'hABC;
    hcount  = 11'd0;
    vcount  = 10'd0;
    step();
    data_in = 12'($urandom);
    step();
    step();
    chk("release_idx0", {8'h00, red, green, blue}, 32'h00AB0054);
    for (int i = 0; i < 300; i++) begin
      data_in = 12'($urandom);
      rand_pixel();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
